// File: rtl/gpu_pixel_writer.sv
// Pixel write stage: clips and addresses rasterizer pixels, buffers them in a
// small FIFO and issues them to the framebuffer arbiter over req/ack.
module gpu_pixel_writer #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 9,
  parameter int unsigned ADDR_BITS   = 19,
  parameter int unsigned DATA_BITS   = 24,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  input  logic [WIDTH_BITS-1:0]  x_i,
  input  logic [HEIGHT_BITS-1:0] y_i,
  input  logic [DATA_BITS-1:0]   color_i,
  input  logic [ADDR_BITS-1:0]   fb_base_i,
  output logic                   mem_req_o,
  output logic [ADDR_BITS-1:0]   mem_addr_o,
  output logic [DATA_BITS-1:0]   mem_data_o,
  input  logic                   mem_ack_i,
  output logic                   clip_o,
  output logic                   busy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned MUL_W = HEIGHT_BITS + WIDTH_BITS;
  localparam int unsigned SUM_W = ((ADDR_BITS > MUL_W) ? ADDR_BITS : MUL_W) + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  // Stage 1 register
  logic      s1_valid_q, s1_valid_d;
  logic      s1_clip_q,  s1_clip_d;
  wr_entry_t s1_entry_q, s1_entry_d;
  logic      clip_q,     clip_d;

  // FIFO
  wr_entry_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q,  count_d;

  // Memory FSM
  state_e                 state_q, state_d;
  logic                   req_q,   req_d;
  logic [ADDR_BITS-1:0]   addr_q,  addr_d;
  logic [DATA_BITS-1:0]   data_q,  data_d;

  logic                   accept_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   clip_flag_c;
  logic [MUL_W-1:0]       prod_c;
  logic [SUM_W-1:0]       sum_c;
  wr_entry_t              head_c;

  // Stage 1 is counted against capacity so it can always drain next edge
  assign pix_ready_o = (32'(count_q) + 32'(s1_valid_q)) < DEPTH;
  assign accept_c    = pix_valid_i & pix_ready_o;

  assign prod_c      = MUL_W'(y_i) * MUL_W'(WIDTH);
  assign sum_c       = SUM_W'(fb_base_i) + SUM_W'(prod_c) + SUM_W'(x_i);
  assign clip_flag_c = (32'(x_i) >= WIDTH) | (32'(y_i) >= HEIGHT);

  assign push_c = s1_valid_q & ~s1_clip_q;
  assign pop_c  = (state_q == ST_IDLE) && (count_q != '0);
  assign head_c = fifo_mem[rd_ptr_q];

  always_comb begin
    s1_valid_d = accept_c;
    s1_clip_d  = s1_clip_q;
    s1_entry_d = s1_entry_q;
    clip_d     = accept_c & clip_flag_c;
    if (accept_c) begin
      s1_clip_d       = clip_flag_c;
      s1_entry_d.addr = sum_c[ADDR_BITS-1:0];
      s1_entry_d.data = color_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Memory FSM next-state and registered request outputs
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_c) begin
          req_d   = 1'b1;
          addr_d  = head_c.addr;
          data_d  = head_c.data;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s1_clip_q  <= 1'b0;
      s1_entry_q <= '0;
      clip_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_clip_q  <= s1_clip_d;
      s1_entry_q <= s1_entry_d;
      clip_q     <= clip_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // FIFO storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= s1_entry_q;
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign clip_o     = clip_q;
  assign busy_o     = s1_valid_q | (count_q != '0) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Scoreboard bench for gpu_pixel_writer: expected writes are queued at
// acceptance and checked in order as requests appear.
module tb_gpu_pixel_writer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [9:0]  x_i;
  logic [8:0]  y_i;
  logic [23:0] color_i;
  logic [18:0] fb_base_i;
  logic        mem_req_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        mem_ack_i;
  logic        clip_o;
  logic        busy_o;

  typedef struct packed {
    logic [18:0] addr;
    logic [23:0] data;
  } exp_t;

  exp_t  sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    sk;
  logic  last_rdy, last_acc;
  logic  cur_clip;
  exp_t  cur_exp;
  logic  mon_pending = 1'b0;
  exp_t  mon_hold;

  gpu_pixel_writer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o),
    .x_i        (x_i),
    .y_i        (y_i),
    .color_i    (color_i),
    .fb_base_i  (fb_base_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_ack_i  (mem_ack_i),
    .clip_o     (clip_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] exp_addr(input int unsigned x, input int unsigned y,
                                           input int unsigned base);
    int unsigned a;
    a = base + y * 640 + x;
    return 19'(a);
  endfunction

  // Request monitor: each new request must match the scoreboard head and hold steady
  always @(negedge clk) begin
    if (n_rst) begin
      if (mon_pending) begin
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== mon_hold.addr || mem_data_o !== mon_hold.data) begin
          miscompares++;
          $display("FAIL req_stable: req=%b addr=%h data=%h, required req=1 addr=%h data=%h",
                   mem_req_o, mem_addr_o, mem_data_o, mon_hold.addr, mon_hold.data);
        end
      end else if (mem_req_o === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_req: addr=%h data=%h, required no request", mem_addr_o, mem_data_o);
        end else begin
          mon_hold = sb.pop_front();
          if (mem_addr_o !== mon_hold.addr || mem_data_o !== mon_hold.data) begin
            miscompares++;
            $display("FAIL write_order: addr=%h data=%h, required addr=%h data=%h",
                     mem_addr_o, mem_data_o, mon_hold.addr, mon_hold.data);
          end
          mon_hold.addr = mem_addr_o;
          mon_hold.data = mem_data_o;
        end
        mon_pending = 1'b1;
      end
      if (mon_pending && mem_ack_i) mon_pending = 1'b0;
    end
  end

  task automatic drive_pix(input int unsigned x, input int unsigned y,
                           input logic [23:0] c, input int unsigned base);
    x_i         = 10'(x);
    y_i         = 9'(y);
    color_i     = c;
    fb_base_i   = 19'(base);
    cur_clip    = (x >= 640) || (y >= 480);
    cur_exp     = {exp_addr(x, y, base), c};
    pix_valid_i = 1'b1;
  endtask

  task automatic drive_stream(input int k);
    drive_pix((k * 37) % 640, (k * 11) % 480, 24'($urandom), 32'h1000 + k);
  endtask

  // One clock of the driver; ends 1 time unit after the rising edge
  task automatic stream_cycle();
    @(negedge clk);
    last_rdy = pix_ready_o;
    @(posedge clk);
    last_acc = last_rdy && pix_valid_i;
    if (last_acc) begin
      if (!cur_clip) sb.push_back(cur_exp);
      sk++;
    end
    #1;
  endtask

  task automatic send_one(input int unsigned x, input int unsigned y,
                          input logic [23:0] c, input int unsigned base);
    drive_pix(x, y, c, base);
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) stream_cycle();
    vectors++;
    if (!last_acc) begin
      miscompares++;
      $display("FAIL accept_timeout: pixel not accepted, required acceptance within 20 cycles");
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy_o !== 1'b0; i++) @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy_o);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d writes outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({pix_ready_o, mem_req_o, mem_addr_o, mem_data_o, clip_o, busy_o} !== {1'b1, 1'b0, 19'd0, 24'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b req=%b addr=%h data=%h clip=%b busy=%b, required 1 0 0 0 0 0",
               pix_ready_o, mem_req_o, mem_addr_o, mem_data_o, clip_o, busy_o);
    end
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    mem_ack_i = 1'b0;
    send_one(3, 2, 24'hFF0000, 0);
    @(negedge clk);
    vectors++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_e0: req=%b busy=%b, required req=0 busy=1", mem_req_o, busy_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_e1: req=%b, required 0", mem_req_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 19'd1283 || mem_data_o !== 24'hFF0000) begin
      miscompares++;
      $display("FAIL single_e2: req=%b addr=%0d data=%h, required req=1 addr=1283 data=ff0000",
               mem_req_o, mem_addr_o, mem_data_o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack: req=%b busy=%b, required req=0 busy=0", mem_req_o, busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clip(input int unsigned x, input int unsigned y);
    mem_ack_i = 1'b1;
    send_one(x, y, 24'h123456, 0);
    @(negedge clk);
    vectors++;
    if (clip_o !== 1'b1) begin
      miscompares++;
      $display("FAIL clip_pulse x=%0d y=%0d: clip=%b, required 1", x, y, clip_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (clip_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clip_width x=%0d y=%0d: clip=%b, required 0", x, y, clip_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clip_idle x=%0d y=%0d: busy=%b req=%b, required 0 0", x, y, busy_o, mem_req_o);
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
  endtask

  task automatic fill_full();
    mem_ack_i = 1'b0;
    sk = 0;
    drive_stream(0);
    repeat (8) begin
      stream_cycle();
      if (last_acc) drive_stream(sk);
    end
    vectors++;
    if (sk != 5 || last_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: accepted=%0d ready=%b, required accepted=5 ready=0", sk, last_rdy);
    end
  endtask

  task automatic test_backpressure();
    fill_full();
    mem_ack_i = 1'b1;
    stream_cycle();
    mem_ack_i = 1'b0;
    stream_cycle();
    vectors++;
    if (last_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ack_edge: ready=%b after ack edge, required 0", last_rdy);
    end
    stream_cycle();
    vectors++;
    if (last_rdy !== 1'b1 || sk != 6) begin
      miscompares++;
      $display("FAIL bp_pop: ready=%b accepted=%0d, required ready=1 accepted=6", last_rdy, sk);
    end
    pix_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (pix_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_refull: ready=%b, required 0", pix_ready_o);
    end
    mem_ack_i = 1'b1;
    wait_idle(200);
    mem_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill_full();
    mem_ack_i = 1'b1;
    for (int i = 0; i < 300 && sk < 20; i++) begin
      stream_cycle();
      if (last_acc && sk < 20) drive_stream(sk);
    end
    pix_valid_i = 1'b0;
    vectors++;
    if (sk != 20) begin
      miscompares++;
      $display("FAIL b2b_accept: accepted=%0d, required 20", sk);
    end
    wait_idle(200);
    mem_ack_i = 1'b0;
  endtask

  task automatic test_wrap();
    mem_ack_i = 1'b1;
    send_one(1, 0, 24'hABCDEF, 32'h7FFFF);
    wait_idle(50);
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic bad;
    mem_ack_i = 1'b0;
    sk = 0;
    drive_stream(0);
    for (int i = 0; i < 30 && sk < 3; i++) begin
      stream_cycle();
      if (last_acc && sk < 3) drive_stream(sk);
    end
    pix_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: req=%b, required 1", mem_req_o);
    end
    #1 n_rst = 1'b0;
    #1;
    vectors++;
    if ({pix_ready_o, mem_req_o, mem_addr_o, mem_data_o, clip_o, busy_o} !== {1'b1, 1'b0, 19'd0, 24'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid: rdy=%b req=%b addr=%h data=%h clip=%b busy=%b, required 1 0 0 0 0 0",
               pix_ready_o, mem_req_o, mem_addr_o, mem_data_o, clip_o, busy_o);
    end
    sb.delete();
    mon_pending = 1'b0;
    #1 n_rst = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_replay: activity after reset release, required none");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst       = 1'b0;
    pix_valid_i = 1'b0;
    x_i         = '0;
    y_i         = '0;
    color_i     = '0;
    fb_base_i   = '0;
    mem_ack_i   = 1'b0;
    test_reset();
    test_single();
    test_clip(640, 0);
    test_clip(0, 480);
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Downstream stage of the rectangle/primitive rasterizers: accepts one (x, y, colour) pixel per cycle over a valid/ready handshake, clips it against the screen, and converts it to a linear framebuffer address. It buffers the write in a small FIFO and issues it to the SRAM/framebuffer arbiter over a req/ack handshake. It decouples rasterizer stepping from memory latency so the rasterizer stalls only when the buffer is full.

## Interface
Parameters:
- WIDTH, 640: screen width in pixels; legal x is 0..WIDTH-1.
- HEIGHT, 480: screen height in pixels; legal y is 0..HEIGHT-1.
- WIDTH_BITS, 10: width of x_i.
- HEIGHT_BITS, 9: width of y_i.
- ADDR_BITS, 19: framebuffer word address width.
- DATA_BITS, 24: colour word width (R,G,B × 8, R in the MSBs).
- DEPTH, 4: FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- pix_valid_i  in  1  pixel present on x_i/y_i/color_i.
- pix_ready_o  out  1  block can accept a pixel this cycle.
- x_i  in  WIDTH_BITS  pixel column.
- y_i  in  HEIGHT_BITS  pixel row.
- color_i  in  DATA_BITS  pixel colour.
- fb_base_i  in  ADDR_BITS  framebuffer base address; sampled with each accepted pixel.
- mem_req_o  out  1  write request to the arbiter.
- mem_addr_o  out  ADDR_BITS  write address, stable while mem_req_o=1.
- mem_data_o  out  DATA_BITS  write data, stable while mem_req_o=1.
- mem_ack_i  in  1  arbiter accepted the write; meaningful only while mem_req_o=1.
- clip_o  out  1  one-cycle pulse: an accepted pixel was discarded as off-screen.
- busy_o  out  1  a pixel is in the stage register, the FIFO, or in flight.

## Operation
- Acceptance: a pixel is accepted on a rising edge where pix_valid_i=1 and pix_ready_o=1.
- Stage 1 (address register): on acceptance, capture the pixel and compute addr = fb_base_i + y_i*WIDTH + x_i, truncated modulo 2^ADDR_BITS. Compute the product at full width (HEIGHT_BITS+WIDTH_BITS bits) before truncating. Also capture the clip flag = (x_i ≥ WIDTH) | (y_i ≥ HEIGHT).
- Stage 2 (FIFO): on the next edge, a valid non-clipped stage-1 entry is pushed {addr, colour}. A clipped entry is dropped and clip_o is high for exactly that cycle.
- pix_ready_o = (fifo_count + stage1_valid) < DEPTH, combinational. This guarantees stage 1 never holds an entry the FIFO cannot take. A push and a pop in the same cycle are both performed, and the count is unchanged.
- Memory FSM, two states:
  - IDLE: if the FIFO is non-empty, pop the head, register mem_addr_o/mem_data_o, set mem_req_o=1, go to WAIT.
  - WAIT: hold mem_req_o, address and data unchanged. When mem_ack_i=1, clear mem_req_o and go to IDLE.
  - mem_ack_i is ignored in IDLE.
- busy_o = stage1_valid | fifo non-empty | (state==WAIT).
- Writes reach memory in acceptance order. Clipped pixels never produce a request.

## Timing
- Reset values: pix_ready_o=1 (FIFO empty), mem_req_o=0, mem_addr_o=0, mem_data_o=0, clip_o=0, busy_o=0, FIFO empty, FSM=IDLE, stage1 invalid.
- Reset mid-operation: all state is cleared immediately (asynchronous). Any pending request and buffered pixels are discarded, not replayed.
- Latency: pixel accepted at edge E0, pushed at E1, mem_req_o asserted after E2 when the FSM is IDLE and the FIFO was empty.
- Request timing: mem_ack_i sampled high at edge Ea drops mem_req_o after Ea. The next request can assert no earlier than after Ea+1. Peak throughput is one write per 2 cycles with single-cycle ack.
- Clipping: clip_o pulses in the cycle after E0 (between E0 and E1).
- FIFO full: with DEPTH entries occupied, pix_ready_o=0 and held inputs are not accepted. pix_ready_o rises in the cycle after the edge that pops an entry.
- Address wrap: a base plus offset ≥ 2^ADDR_BITS wraps silently; no error is flagged.

## Test plan
- Single pixel: fb_base=0, (x=3, y=2, colour=0xFF0000) → mem_req_o rises 2 edges after acceptance with mem_addr_o=1283 and mem_data_o=0xFF0000. Ack after 3 cycles → req drops, busy_o falls after the ack edge.
- Clipping: (x=640, y=0) and (x=0, y=480) → clip_o pulses once for each, no mem_req_o, busy_o returns to 0 2 edges after acceptance.
- Backpressure: mem_ack_i held 0 and pixels streamed continuously → exactly 1 in flight + 4 buffered are accepted, then pix_ready_o=0. Release ack for 1 cycle → pix_ready_o=1 for one acceptance. All 5 addresses emerge in order.
- Wrap: fb_base=0x7FFFF, (x=1, y=0) → mem_addr_o=0x00000.
- Reset mid-burst: 3 pixels queued with mem_req_o=1, n_rst pulsed low between edges → outputs go to reset values immediately, and no further requests after release.
- Simultaneous push/pop at full FIFO with a same-cycle ack → count is unchanged and ordering is preserved.
